pipeline_stall_controller: RTL
==============================

// Module: pipeline_stall_controller
// PURPOSE
//  Central sequencer for the 5-stage RV32I pipeline register enables and flushes (PC, IF/ID, ID/EX, EX/MEM, MEM/WB).
//  Detects load-use hazards against the ID stage, squashes wrong-path fetch on ID-resolved branch/jump, and freezes the pipe on data-memory wait.
//  Keeps saturating stall/flush performance counters and a sticky memory-timeout flag.
// PARAMETERS
//  LOAD_STALL_CYCLES  1    bubbles inserted per load-use hazard (>=1)
//  MEM_TIMEOUT        255  MEM_WAIT cycles before MemTimeout sets (>=1)
//  CNT_WIDTH          16   width of performance counters
// PORTS
//  CLK              in   1   clock; all state updates on posedge
//  Reset            in   1   synchronous, active-low reset
//  ID_EX_MemToReg   in   1   instruction in EX is a load
//  ID_EX_RD         in   5   destination register of the EX instruction
//  IF_ID_RS1/RS2    in   5   source registers of the ID instruction
//  IF_ID_UsesRS1/2  in   1   ID instruction actually reads RS1/RS2
//  BranchTaken      in   1   ID branch resolved taken (Branch & ONE)
//  Jump             in   1   ID instruction is JAL/JALR
//  IMemValid        in   1   fetch data valid this cycle
//  DMemReq          in   1   MEM stage is issuing a load/store
//  DMemAck          in   1   data memory completes the request
//  PC_EN, IF_ID_EN, ID_EX_EN, EX_MEM_EN, MEM_WB_EN  out 1  stage-register enables
//  IF_ID_Flush, ID_EX_Flush  out 1  load bubble (NOP) into the register
//  StallCount, FlushCount    out CNT_WIDTH  saturating counters
//  MemTimeout       out  1   sticky; set when MEM_WAIT reaches MEM_TIMEOUT
// BEHAVIOUR
//  Reset (Reset==0 at posedge): state=RUN, counters=0, MemTimeout=0. While Reset==0 all *_EN=0, both flushes=1.
//  Enables and flushes are combinational from state plus inputs. Counters and state are registered.
//  loadUse = ID_EX_MemToReg & ID_EX_RD!=0 & ((UsesRS1 & RD==RS1) | (UsesRS2 & RD==RS2)).
//  States (enum hz_state_t): RUN, LOAD_STALL, MEM_WAIT. Priority within RUN: mem wait > load-use > redirect > fetch stall.
//  RUN, DMemReq & !DMemAck: all EN=0, no flush. Next state MEM_WAIT, wait counter=1.
//  RUN, loadUse: PC_EN=IF_ID_EN=0 and ID_EX_Flush=1; the other EN=1. Any branch/jump is ignored (re-resolved after the stall).
//    If LOAD_STALL_CYCLES>1, go to LOAD_STALL with bubble counter=1; otherwise stay in RUN.
//  RUN, BranchTaken|Jump (no stall): all EN=1, IF_ID_Flush=1 (squash wrong-path fetch).
//  RUN, !IMemValid (no higher event): PC_EN=0, IF_ID_Flush=1, downstream EN=1.
//  RUN, otherwise: all EN=1, no flush.
//  LOAD_STALL: same outputs as a RUN load-use cycle. Counter increments each cycle; at LOAD_STALL_CYCLES go to RUN.
//    A DMemReq & !DMemAck in this state takes precedence: freeze and go to MEM_WAIT; the bubble count is lost and loadUse is re-evaluated afterwards.
//  MEM_WAIT: all EN=0, no flush, wait counter increments (saturating). DMemAck=1 -> all EN=1 that cycle, next state RUN.
//    Counter reaching MEM_TIMEOUT sets MemTimeout; the state stays in MEM_WAIT until ack.
//  StallCount: +1 on every cycle with PC_EN=0 and Reset==1. FlushCount: +1 on every cycle with IF_ID_Flush|ID_EX_Flush and Reset==1.
//    Both saturate at all-ones and never wrap.
//  Reset mid-stall/wait: state returns to RUN next cycle and counters clear. Outstanding memory request ownership belongs to the memory side.
//  The hazard comparator covers the EX stage only. EX/MEM and MEM/WB dependencies are resolved by forwarding, not by this block.
// STRUCTURE
//  RISCV_PKG: hz_state_t enum, ADDRESS_PORT_WIDTH reuse, and a STALL_NONE/LOAD/MEM/FETCH reason enum for debug.
//  Sub-module load_use_detector (combinational loadUse compare). FSM, counters and output decode live in this block.
// TESTING
//  1. lw x5 in EX, add reading x5 in ID -> exactly 1 cycle PC_EN=0, ID_EX_Flush=1. StallCount=1. Next cycle all EN=1.
//  2. Same hazard with ID_EX_RD=0 or UsesRS1=0 -> no stall; all EN=1.
//  3. BranchTaken=1 with no hazard -> IF_ID_Flush=1, PC_EN=1 for 1 cycle. FlushCount=1.
//  4. loadUse and BranchTaken in the same cycle -> stall only (no IF_ID_Flush). Next cycle BranchTaken -> flush.
//  5. DMemReq=1, ack withheld 3 cycles -> all EN=0 for 3 cycles, EN=1 on the ack cycle. MEM_TIMEOUT=2 run sets MemTimeout and it stays set.
//  6. Reset=0 asserted during MEM_WAIT -> next cycle state RUN, counters 0, flushes=1 while low. LOAD_STALL_CYCLES=3 gives 3 bubbles.

Source files
------------

// File: rtl/pipeline_stall_controller_pkg.sv
// Shared types for the pipeline stall/flush sequencer: FSM state encoding,
// register-address width and a stall-reason classification for debug views.
package pipeline_stall_controller_pkg;

   localparam int ADDRESS_PORT_WIDTH = 5;

   typedef enum logic [1:0] {
      HZ_RUN        = 2'd0,
      HZ_LOAD_STALL = 2'd1,
      HZ_MEM_WAIT   = 2'd2
   } hz_state_t;

   typedef enum logic [1:0] {
      STALL_NONE  = 2'd0,
      STALL_LOAD  = 2'd1,
      STALL_MEM   = 2'd2,
      STALL_FETCH = 2'd3
   } stall_reason_t;

endpackage

// File: rtl/pipeline_stall_controller_if.sv
// Hazard inputs and stage-control outputs exchanged between the RV32I
// pipeline datapath (master) and the stall controller (slave).
interface pipeline_stall_controller_if
   import pipeline_stall_controller_pkg::*;
#(
   parameter int CNT_WIDTH = 16
);

   logic                          ID_EX_MemToReg;
   logic [ADDRESS_PORT_WIDTH-1:0] ID_EX_RD;
   logic [ADDRESS_PORT_WIDTH-1:0] IF_ID_RS1;
   logic [ADDRESS_PORT_WIDTH-1:0] IF_ID_RS2;
   logic                          IF_ID_UsesRS1;
   logic                          IF_ID_UsesRS2;
   logic                          BranchTaken;
   logic                          Jump;
   logic                          IMemValid;
   logic                          DMemReq;
   logic                          DMemAck;

   logic                          PC_EN;
   logic                          IF_ID_EN;
   logic                          ID_EX_EN;
   logic                          EX_MEM_EN;
   logic                          MEM_WB_EN;
   logic                          IF_ID_Flush;
   logic                          ID_EX_Flush;
   logic [CNT_WIDTH-1:0]          StallCount;
   logic [CNT_WIDTH-1:0]          FlushCount;
   logic                          MemTimeout;

   modport master (
      output ID_EX_MemToReg, ID_EX_RD, IF_ID_RS1, IF_ID_RS2,
             IF_ID_UsesRS1, IF_ID_UsesRS2, BranchTaken, Jump,
             IMemValid, DMemReq, DMemAck,
      input  PC_EN, IF_ID_EN, ID_EX_EN, EX_MEM_EN, MEM_WB_EN,
             IF_ID_Flush, ID_EX_Flush, StallCount, FlushCount, MemTimeout
   );

   modport slave (
      input  ID_EX_MemToReg, ID_EX_RD, IF_ID_RS1, IF_ID_RS2,
             IF_ID_UsesRS1, IF_ID_UsesRS2, BranchTaken, Jump,
             IMemValid, DMemReq, DMemAck,
      output PC_EN, IF_ID_EN, ID_EX_EN, EX_MEM_EN, MEM_WB_EN,
             IF_ID_Flush, ID_EX_Flush, StallCount, FlushCount, MemTimeout
   );

endinterface

// File: rtl/pipeline_stall_controller_load_use_detector.sv
// Combinational load-use compare between the load in EX and the sources of
// the instruction in ID. x0 never creates a dependency.
module load_use_detector
   import pipeline_stall_controller_pkg::*;
(
   input  logic                          ID_EX_MemToReg,
   input  logic [ADDRESS_PORT_WIDTH-1:0] ID_EX_RD,
   input  logic [ADDRESS_PORT_WIDTH-1:0] IF_ID_RS1,
   input  logic [ADDRESS_PORT_WIDTH-1:0] IF_ID_RS2,
   input  logic                          IF_ID_UsesRS1,
   input  logic                          IF_ID_UsesRS2,
   output logic                          LoadUse
);

   logic rs1_hit;
   logic rs2_hit;

   assign rs1_hit = IF_ID_UsesRS1 && (ID_EX_RD == IF_ID_RS1);
   assign rs2_hit = IF_ID_UsesRS2 && (ID_EX_RD == IF_ID_RS2);
   assign LoadUse = ID_EX_MemToReg && (ID_EX_RD != '0) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipeline_stall_controller.sv
// Central sequencer for the 5-stage RV32I pipeline: stage-register enables,
// bubble/squash flushes, load-use stalls, data-memory wait freeze, saturating
// stall/flush counters and a sticky memory-timeout flag.
module pipeline_stall_controller
   import pipeline_stall_controller_pkg::*;
#(
   parameter int LOAD_STALL_CYCLES = 1,
   parameter int MEM_TIMEOUT       = 255,
   parameter int CNT_WIDTH         = 16
) (
   input logic                          CLK,
   input logic                          Reset,
   pipeline_stall_controller_if.slave   bus
);

   localparam logic [1:0] ST_RUN        = HZ_RUN;
   localparam logic [1:0] ST_LOAD_STALL = HZ_LOAD_STALL;
   localparam logic [1:0] ST_MEM_WAIT   = HZ_MEM_WAIT;

   localparam int BUB_W  = $clog2(LOAD_STALL_CYCLES + 1);
   localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

   localparam logic [BUB_W-1:0]  BUB_LAST = BUB_W'(LOAD_STALL_CYCLES);
   localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);
   localparam logic [WAIT_W-1:0] WAIT_ONE = WAIT_W'(1);

   // Enable vector order: {PC, IF/ID, ID/EX, EX/MEM, MEM/WB}
   localparam logic [4:0] EN_ALL   = 5'b11111;
   localparam logic [4:0] EN_NONE  = 5'b00000;
   localparam logic [4:0] EN_LOAD  = 5'b00111;
   localparam logic [4:0] EN_FETCH = 5'b01111;
   // Flush vector order: {IF_ID_Flush, ID_EX_Flush}
   localparam logic [1:0] FL_NONE  = 2'b00;
   localparam logic [1:0] FL_LOAD  = 2'b01;
   localparam logic [1:0] FL_FETCH = 2'b10;
   localparam logic [1:0] FL_RESET = 2'b11;

   logic                 load_use;
   logic                 mem_stall;
   logic [1:0]           state_q, state_d;
   logic [BUB_W-1:0]     bub_q, bub_d;
   logic [WAIT_W-1:0]    wait_q, wait_d;
   logic                 timeout_set;
   logic                 timeout_q;
   logic [4:0]           en_dec, en_out;
   logic [1:0]           fl_dec, fl_out;
   logic [CNT_WIDTH-1:0] stall_cnt_q;
   logic [CNT_WIDTH-1:0] flush_cnt_q;

   function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   load_use_detector u_load_use (
      .ID_EX_MemToReg (bus.ID_EX_MemToReg),
      .ID_EX_RD       (bus.ID_EX_RD),
      .IF_ID_RS1      (bus.IF_ID_RS1),
      .IF_ID_RS2      (bus.IF_ID_RS2),
      .IF_ID_UsesRS1  (bus.IF_ID_UsesRS1),
      .IF_ID_UsesRS2  (bus.IF_ID_UsesRS2),
      .LoadUse        (load_use)
   );

   assign mem_stall = bus.DMemReq && !bus.DMemAck;

   // Output decode and next-state selection; memory freeze outranks all else
   always_comb begin
      en_dec      = EN_ALL;
      fl_dec      = FL_NONE;
      state_d     = state_q;
      bub_d       = bub_q;
      wait_d      = wait_q;
      timeout_set = 1'b0;
      case (state_q)
         ST_MEM_WAIT: begin
            if (bus.DMemAck) begin
               state_d = ST_RUN;
            end else begin
               en_dec = EN_NONE;
               if (wait_q < WAIT_MAX) wait_d = wait_q + 1'b1;
               timeout_set = (wait_d >= WAIT_MAX);
            end
         end
         ST_LOAD_STALL: begin
            if (mem_stall) begin
               // Remaining bubbles are dropped; the hazard is re-checked after the wait
               en_dec      = EN_NONE;
               state_d     = ST_MEM_WAIT;
               wait_d      = WAIT_ONE;
               timeout_set = (WAIT_ONE >= WAIT_MAX);
            end else begin
               en_dec = EN_LOAD;
               fl_dec = FL_LOAD;
               bub_d  = bub_q + 1'b1;
               if (bub_d == BUB_LAST) state_d = ST_RUN;
            end
         end
         default: begin
            if (mem_stall) begin
               en_dec      = EN_NONE;
               state_d     = ST_MEM_WAIT;
               wait_d      = WAIT_ONE;
               timeout_set = (WAIT_ONE >= WAIT_MAX);
            end else if (load_use) begin
               // A branch/jump in ID is ignored here and re-resolved after the bubble
               en_dec = EN_LOAD;
               fl_dec = FL_LOAD;
               if (LOAD_STALL_CYCLES > 1) begin
                  state_d = ST_LOAD_STALL;
                  bub_d   = BUB_W'(1);
               end
            end else if (bus.BranchTaken || bus.Jump) begin
               fl_dec = FL_FETCH;
            end else if (!bus.IMemValid) begin
               en_dec = EN_FETCH;
               fl_dec = FL_FETCH;
            end
         end
      endcase
   end

   assign en_out = Reset ? en_dec : EN_NONE;
   assign fl_out = Reset ? fl_dec : FL_RESET;

   assign bus.PC_EN       = en_out[4];
   assign bus.IF_ID_EN    = en_out[3];
   assign bus.ID_EX_EN    = en_out[2];
   assign bus.EX_MEM_EN   = en_out[1];
   assign bus.MEM_WB_EN   = en_out[0];
   assign bus.IF_ID_Flush = fl_out[1];
   assign bus.ID_EX_Flush = fl_out[0];
   assign bus.StallCount  = stall_cnt_q;
   assign bus.FlushCount  = flush_cnt_q;
   assign bus.MemTimeout  = timeout_q;

   // FSM, bubble/wait counters, saturating performance counters, sticky timeout
   always_ff @(posedge CLK) begin
      if (!Reset) begin
         state_q     <= ST_RUN;
         bub_q       <= '0;
         wait_q      <= '0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
         timeout_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         bub_q   <= bub_d;
         wait_q  <= wait_d;
         if (!en_out[4]) stall_cnt_q <= sat_inc(stall_cnt_q);
         if (|fl_out)    flush_cnt_q <= sat_inc(flush_cnt_q);
         if (timeout_set) timeout_q <= 1'b1;
      end
   end

endmodule
